// File: rtl/prefix_adder_scheduler_if.sv
// Request/result bundle between arithmetic clients and the shared wide-add scheduler.
// Operands are packed per requester: requester i occupies bits [i*W +: W].
interface prefix_adder_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int WORDS = 4
);
    localparam int W   = 16 * WORDS;
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic              res_valid;
    logic              res_ready;
    logic [IDW-1:0]    res_id;
    logic [W-1:0]      res_sum;
    logic              res_cout;

    modport master (
        output req_valid, req_a, req_b, req_cin, res_ready,
        input  req_ready, res_valid, res_id, res_sum, res_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, res_ready,
        output req_ready, res_valid, res_id, res_sum, res_cout
    );
endinterface

// File: rtl/prefix_adder_scheduler.sv
// Round-robin scheduler sharing one 16-bit Kogge-Stone slice among NREQ wide-add requesters;
// operands stream through the slice one word per cycle with the carry chained in a register.
module prefix_adder_scheduler #(
    parameter int NREQ  = 4,
    parameter int WORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    prefix_adder_scheduler_if.slave   bus
);
    localparam int W   = 16 * WORDS;
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int KW  = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic [WORDS-1:0][15:0]    a_r;
    logic [WORDS-1:0][15:0]    b_r;
    logic [WORDS-1:0][15:0]    sum_r;
    logic                      carry_r;
    logic [KW-1:0]             k_r;
    logic [IDW-1:0]            owner_r;
    logic [IDW-1:0]            rr_ptr_r;

    logic [NREQ-1:0][W-1:0]    req_a_s;
    logic [NREQ-1:0][W-1:0]    req_b_s;
    logic [IDW-1:0]            win_s;
    logic [IDW-1:0]            scan_s;
    logic                      any_s;
    logic [15:0]               a_w_s;
    logic [15:0]               b_w_s;
    logic [15:0]               s_w_s;
    logic                      c_out_s;

    // Parallel-prefix add; cin is folded into bit 0's generate so every g[i] is a true carry.
    function automatic logic [16:0] prefix_add16(input logic [15:0] a,
                                                 input logic [15:0] b,
                                                 input logic        cin);
        logic [15:0] p0;
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] gn;
        logic [15:0] pn;
        p0   = a ^ b;
        g    = a & b;
        p    = p0;
        g[0] = g[0] | (p0[0] & cin);
        for (int lvl = 0; lvl < 4; lvl++) begin
            gn = g;
            pn = p;
            for (int i = 0; i < 16 - (1 << lvl); i++) begin
                gn[i + (1 << lvl)] = g[i + (1 << lvl)] | (p[i + (1 << lvl)] & g[i]);
                pn[i + (1 << lvl)] = p[i + (1 << lvl)] & p[i];
            end
            g = gn;
            p = pn;
        end
        return {g[15], p0 ^ {g[14:0], cin}};
    endfunction

    assign req_a_s = bus.req_a;
    assign req_b_s = bus.req_b;

    // Shared adder slice on the current word
    always_comb begin
        a_w_s            = a_r[k_r];
        b_w_s            = b_r[k_r];
        {c_out_s, s_w_s} = prefix_add16(a_w_s, b_w_s, carry_r);
    end

    // Round-robin winner: first valid requester at or above rr_ptr, wrapping
    always_comb begin
        win_s  = '0;
        any_s  = 1'b0;
        scan_s = '0;
        for (int off = 0; off < NREQ; off++) begin
            scan_s = IDW'((int'(rr_ptr_r) + off) % NREQ);
            if (!any_s && bus.req_valid[scan_s]) begin
                any_s = 1'b1;
                win_s = scan_s;
            end else begin
                any_s = any_s;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_s) state_s = CALC;
                else       state_s = IDLE;
            end
            CALC: begin
                if (k_r == KW'(WORDS - 1)) state_s = DONE;
                else                       state_s = CALC;
            end
            DONE: begin
                if (bus.res_ready) state_s = IDLE;
                else               state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Operand capture, word sequencing and round-robin pointer update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            sum_r    <= '0;
            carry_r  <= 1'b0;
            k_r      <= '0;
            owner_r  <= '0;
            rr_ptr_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        a_r     <= req_a_s[win_s];
                        b_r     <= req_b_s[win_s];
                        carry_r <= bus.req_cin[win_s];
                        k_r     <= '0;
                        owner_r <= win_s;
                    end else begin
                        k_r     <= k_r;
                    end
                end
                CALC: begin
                    sum_r[k_r] <= s_w_s;
                    carry_r    <= c_out_s;
                    k_r        <= k_r + KW'(1);
                end
                DONE: begin
                    // Pointer advances only once the result has actually left
                    if (bus.res_ready) begin
                        rr_ptr_r <= (owner_r == IDW'(NREQ - 1)) ? '0 : owner_r + IDW'(1);
                    end else begin
                        rr_ptr_r <= rr_ptr_r;
                    end
                end
                default: begin
                    k_r <= '0;
                end
            endcase
        end
    end

    // Output decode
    always_comb begin
        bus.req_ready = '0;
        bus.res_valid = 1'b0;
        bus.res_id    = owner_r;
        bus.res_sum   = sum_r;
        bus.res_cout  = carry_r;
        case (state_r)
            IDLE: begin
                if (any_s && !rst) bus.req_ready[win_s] = 1'b1;
                else               bus.req_ready = '0;
            end
            DONE: begin
                bus.res_valid = 1'b1;
            end
            default: begin
                bus.res_valid = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_prefix_adder_scheduler.sv
// Directed and round-robin checks for prefix_adder_scheduler with NREQ=4, WORDS=4.
module tb_prefix_adder_scheduler;
    localparam int NREQ  = 4;
    localparam int WORDS = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prefix_adder_scheduler_if #(.NREQ(NREQ), .WORDS(WORDS)) bus ();

    logic [3:0][63:0] a_arr;
    logic [3:0][63:0] b_arr;
    logic [3:0]       cin_arr;
    assign bus.req_a   = a_arr;
    assign bus.req_b   = b_arr;
    assign bus.req_cin = cin_arr;

    prefix_adder_scheduler #(.NREQ(NREQ), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  id;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] sum;
        logic        cout;
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic [64:0] full;
    } exp_t;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    exp_t expq[$];
    vec_t vecs[7];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_op(input logic [1:0] id, input logic [63:0] a, input logic [63:0] b,
                          input logic cin);
        a_arr[id]   = a;
        b_arr[id]   = b;
        cin_arr[id] = cin;
    endtask

    task automatic wait_ready(input logic [3:0] want);
        int n = 0;
        while (bus.req_ready !== want && n < 30) begin
            step();
            n++;
        end
        check("accept", 64'(bus.req_ready), 64'(want));
    endtask

    task automatic wait_valid(input int start, output int lat);
        lat = start;
        while (bus.res_valid !== 1'b1 && lat < 30) begin
            step();
            lat++;
        end
    endtask

    task automatic do_op(input vec_t v);
        int lat;
        set_op(v.id, v.a, v.b, v.cin);
        bus.req_valid = 4'b0001 << v.id;
        #1;
        wait_ready(4'b0001 << v.id);
        step();
        bus.req_valid = 4'b0000;
        wait_valid(1, lat);
        check("latency", 64'(lat), 64'd5);
        check("sum", bus.res_sum, v.sum);
        check("cout", 64'(bus.res_cout), 64'(v.cout));
        check("id", 64'(bus.res_id), 64'(v.id));
    endtask

    initial begin
        int   lat;
        int   cyc;
        int   last_acc;
        int   ops_done;
        logic [1:0] exp_g;
        logic [1:0] g;
        logic [3:0] chg;
        exp_t e;

        vecs[0] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1};
        vecs[1] = '{2'd2, 64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 64'h0000_0000_0001_0000, 1'b0};
        vecs[2] = '{2'd1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                    64'h2222_2222_2222_2211, 1'b0};
        vecs[3] = '{2'd3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 64'h1, 1'b1};
        vecs[4] = '{2'd0, 64'h0, 64'h0, 1'b0, 64'h0, 1'b0};
        vecs[5] = '{2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[6] = '{2'd2, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
                    64'h0001_0000_0001_0000, 1'b0};

        a_arr         = '0;
        b_arr         = '0;
        cin_arr       = 4'b0000;
        bus.res_ready = 1'b1;
        bus.req_valid = 4'b1111;
        rst           = 1'b1;
        step();
        check("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("rst_res_sum", bus.res_sum, 64'd0);
        check("rst_res_cout", 64'(bus.res_cout), 64'd0);
        check("rst_res_id", 64'(bus.res_id), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        bus.req_valid = 4'b0000;
        rst           = 1'b0;
        step();

        // Directed vector table
        for (int i = 0; i < 7; i++) do_op(vecs[i]);
        step();

        // Round-robin with all requesters valid from reset
        rst = 1'b1;
        step();
        for (int i = 0; i < 4; i++) set_op(2'(i), {$urandom(), $urandom()}, {$urandom(), $urandom()},
                                           1'($urandom_range(1)));
        bus.req_valid = 4'b1111;
        rst           = 1'b0;
        #1;
        cyc = 0; last_acc = -1; ops_done = 0; exp_g = 2'd0; chg = 4'b0000; g = 2'd0;
        while (ops_done < 1000 && cyc < 8000) begin
            if (bus.req_ready != 4'b0000) begin
                for (int i = 0; i < 4; i++) if (bus.req_ready[i]) g = 2'(i);
                check("rr_grant", 64'(bus.req_ready), 64'(4'b0001 << exp_g));
                if (last_acc >= 0) check("rr_spacing", 64'(cyc - last_acc), 64'd6);
                e.id   = g;
                e.full = {1'b0, a_arr[g]} + {1'b0, b_arr[g]} + 65'(cin_arr[g]);
                expq.push_back(e);
                chg[g]   = 1'b1;
                last_acc = cyc;
                exp_g    = exp_g + 2'd1;
            end
            if (bus.res_valid) begin
                check("rr_pending", 64'(expq.size() != 0), 64'd1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    check("rr_sum", bus.res_sum, e.full[63:0]);
                    check("rr_cout", 64'(bus.res_cout), 64'(e.full[64]));
                    check("rr_id", 64'(bus.res_id), 64'(e.id));
                end
                ops_done++;
            end
            step();
            cyc++;
            for (int i = 0; i < 4; i++)
                if (chg[i]) set_op(2'(i), {$urandom(), $urandom()}, {$urandom(), $urandom()},
                                   1'($urandom_range(1)));
            chg = 4'b0000;
        end
        check("rr_ops", 64'(ops_done), 64'd1000);
        bus.req_valid = 4'b0000;
        step();

        // Backpressure: result held while res_ready is low
        bus.res_ready = 1'b0;
        set_op(2'd1, 64'd1, 64'd2, 1'b0);
        bus.req_valid = 4'b0010;
        #1;
        wait_ready(4'b0010);
        step();
        set_op(2'd3, 64'd5, 64'd6, 1'b1);
        bus.req_valid = 4'b1000;
        wait_valid(1, lat);
        check("bp_latency", 64'(lat), 64'd5);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 64'(bus.res_valid), 64'd1);
            check("bp_sum", bus.res_sum, 64'd3);
            check("bp_id", 64'(bus.res_id), 64'd1);
            check("bp_ready", 64'(bus.req_ready), 64'd0);
            step();
        end
        bus.res_ready = 1'b1;
        step();
        check("bp_next_accept", 64'(bus.req_ready), 64'(4'b1000));
        step();
        bus.req_valid = 4'b0000;
        wait_valid(1, lat);
        check("bp_next_sum", bus.res_sum, 64'd12);
        check("bp_next_id", 64'(bus.res_id), 64'd3);
        step();

        // Reset during CALC discards the operation and clears the pointer
        do_op('{2'd1, 64'd7, 64'd8, 1'b0, 64'd15, 1'b0});
        set_op(2'd2, 64'h100, 64'h200, 1'b0);
        bus.req_valid = 4'b0100;
        #1;
        wait_ready(4'b0100);
        step();
        bus.req_valid = 4'b0000;
        step();
        rst           = 1'b1;
        bus.req_valid = 4'b1111;
        #1;
        check("midrst_valid", 64'(bus.res_valid), 64'd0);
        check("midrst_sum", bus.res_sum, 64'd0);
        check("midrst_cout", 64'(bus.res_cout), 64'd0);
        check("midrst_id", 64'(bus.res_id), 64'd0);
        check("midrst_ready", 64'(bus.req_ready), 64'd0);
        step();
        step();
        set_op(2'd0, 64'h11, 64'h22, 1'b0);
        set_op(2'd3, 64'hAAAA_0000_0000_0000, 64'h5555_0000_0000_0000, 1'b1);
        bus.req_valid = 4'b1001;
        rst           = 1'b0;
        #1;
        check("post_rst_grant", 64'(bus.req_ready), 64'(4'b0001));

        // Requester 1 appears while busy, then withdraws before the result completes
        step();
        set_op(2'd1, 64'd1, 64'd1, 1'b0);
        bus.req_valid = 4'b1010;
        step();
        step();
        bus.req_valid = 4'b1000;
        wait_valid(3, lat);
        check("wd_latency", 64'(lat), 64'd5);
        check("wd_first_id", 64'(bus.res_id), 64'd0);
        check("wd_first_sum", bus.res_sum, 64'h33);
        step();
        check("wd_grant", 64'(bus.req_ready), 64'(4'b1000));
        step();
        bus.req_valid = 4'b0000;
        wait_valid(1, lat);
        check("wd_next_id", 64'(bus.res_id), 64'd3);
        check("wd_next_sum", bus.res_sum, 64'hFFFF_0000_0000_0001);
        check("wd_next_cout", 64'(bus.res_cout), 64'd0);
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/prefix_adder_scheduler.md
# prefix_adder_scheduler

Multi-cycle wide-add scheduler that shares a single 16-bit parallel-prefix adder slice among NREQ requesters. Each request is a (16·WORDS)-bit add with carry-in. The block arbitrates requests round-robin, then sequences the operands through the slice one 16-bit word per cycle, chaining the carry in a register. It returns the full sum and carry-out on a valid/ready result port tagged with the requester id. It sits between the arithmetic clients and the adder slice, and is the only driver of that slice.

## Interface
- NREQ, 4, number of requesters (2..8)
- WORDS, 4, 16-bit words per operand (1..8); operand width W = 16·WORDS
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  request pending, one bit per requester
- req_ready  output  NREQ  request accepted this cycle (one-hot or zero)
- req_a  input  NREQ·W  operand A, requester i at bits [i·W +: W]
- req_b  input  NREQ·W  operand B, same packing
- req_cin  input  NREQ  carry-in per requester
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_id  output  clog2(NREQ) (min 1)  index of requester that owns the result
- res_sum  output  W  sum
- res_cout  output  1  carry-out of the top word

## Operation
- One internal 16-bit adder slice, with inputs a_w, b_w, c_in and outputs s_w, c_out; purely combinational.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - Winner g is the first i with req_valid[i] set, scanning from rr_ptr upward modulo NREQ.
  - If any request is valid, req_ready[g]=1 (combinational, this cycle only). On the edge the block latches req_a/req_b for g, sets carry_reg to req_cin[g], word index k to 0, owner to g, and moves to CALC.
  - With no request valid, req_ready is all zero and the FSM stays in IDLE.
- CALC:
  - The slice adds word k of the latched A and B with carry_reg.
  - On each edge: sum_reg word k ← s_w, carry_reg ← c_out, k ← k+1.
  - When k = WORDS−1 the FSM moves to DONE.
  - req_ready is all zero throughout.
- DONE:
  - res_valid=1; res_sum, res_cout (= carry_reg) and res_id (= owner) are held stable.
  - On res_valid && res_ready: rr_ptr ← (owner+1) mod NREQ, then go to IDLE.
  - The FSM stays in DONE indefinitely while res_ready=0.
- Arithmetic: res_sum = (A + B + cin) mod 2^W; res_cout = bit W of the full sum.
- Requesters must hold req_valid and their operands stable until req_ready. Dropping req_valid before that is legal and simply withdraws the request.
- No new request is accepted until the current result is consumed (single outstanding operation).

## Timing
- Reset (asynchronous assert, synchronous release):
  - FSM → IDLE; rr_ptr, k, owner, carry_reg, sum_reg → 0.
  - Outputs: res_valid=0, res_sum=0, res_cout=0, res_id=0, req_ready=0.
- Reset mid-operation: the in-flight operation is discarded with no result. The requester must re-request.
- Latency: accept at edge t (req_ready high in cycle t). res_valid rises in cycle t+1+WORDS, i.e. t+5 for WORDS=4.
- Throughput with res_ready held high: one operation per WORDS+2 cycles.
  - Sequence: IDLE accept cycle, WORDS CALC cycles, one DONE cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ−1,0. No requester waits more than NREQ−1 operations.
- Simultaneous events:
  - A req_valid that changes in the same cycle as a DONE handshake is evaluated in the following IDLE cycle.
  - rr_ptr updates only on the result handshake, not on acceptance.
- WORDS=1: CALC lasts exactly one cycle.

## Test plan
- Carry ripple across words, WORDS=4: requester 0, A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, cin=0 → res_sum=0x0, res_cout=1, res_id=0, res_valid 5 cycles after acceptance.
- Carry-in only: requester 2, A=0x0000_0000_0000_FFFF, B=0, cin=1 → res_sum=0x0000_0000_0001_0000, res_cout=0, res_id=2.
- Round-robin, all four requesters valid from reset with res_ready=1:
  - req_ready pulses go to 0,1,2,3,0 in order, spaced 6 cycles apart.
  - Each result is correct against a 64-bit reference sum on random operands (≥1000 operations).
- Backpressure: hold res_ready=0 for 10 cycles after res_valid rises → res_valid, res_sum and res_id stay stable, req_ready stays 0; releasing res_ready completes the handshake and the next accept occurs in the following cycle.
- Reset mid-CALC: assert rst 2 cycles after acceptance → outputs go to reset values immediately. After release, rr_ptr=0 and no res_valid appears for the aborted operation.
- Withdrawn request: requester 1 raises req_valid while the block is busy, then drops it before DONE completes → requester 1 is never granted, and the next grant goes to another valid requester.
